// File: rtl/rtc_time_keeper.sv
// Time-of-day keeper: 1 Hz prescaler, 24-hour seconds/minutes/hours counters,
// validated loads, and registered BCD display digits in 12- or 24-hour form.
module rtc_time_keeper #(
    parameter int TICK_DIV = 50000000,
    parameter int PRESC_W  = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       hour_format,
    input  logic       set_en,
    input  logic [5:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    output logic [3:0] h_digit_1,
    output logic [3:0] h_digit_0,
    output logic [3:0] m_digit_1,
    output logic [3:0] m_digit_0,
    output logic [3:0] s_digit_1,
    output logic [3:0] s_digit_0,
    output logic       am_pm_form,
    output logic       second_tick,
    output logic       day_wrap,
    output logic       set_err
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    // Values are bounded to 0..59, so a short compare/subtract chain replaces a divider.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        if (v >= 6'd50) begin
            tens  = 4'd5;
            units = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            tens  = 4'd4;
            units = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            tens  = 4'd3;
            units = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            tens  = 4'd2;
            units = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            tens  = 4'd1;
            units = 4'(v - 6'd10);
        end else begin
            tens  = 4'd0;
            units = v[3:0];
        end
        return {tens, units};
    endfunction

    function automatic logic [5:0] disp_hour(input logic [5:0] h, input logic fmt_12);
        if (!fmt_12)
            return h;
        if (h == 6'd0)
            return 6'd12;
        if (h > 6'd12)
            return h - 6'd12;
        return h;
    endfunction

    logic [PRESC_W-1:0] presc_p0;
    logic [5:0]         hours_p0;
    logic [5:0]         minutes_p0;
    logic [5:0]         seconds_p0;
    logic               tick_p0;
    logic               wrap_p0;
    logic               err_p0;

    logic tick;
    logic set_legal;
    logic load;
    logic sec_last;
    logic min_last;
    logic hour_last;

    assign tick      = run && (presc_p0 == PRESC_LAST);
    assign set_legal = (set_hours <= 6'd23) && (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
    assign load      = set_en && set_legal;
    assign sec_last  = (seconds_p0 == 6'd59);
    assign min_last  = (minutes_p0 == 6'd59);
    assign hour_last = (hours_p0 == 6'd23);

    // Stage p0: prescaler, time counters and the event flags that accompany them.
    // A legal load wins over a coincident tick; a rejected load leaves the tick alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_p0   <= '0;
            hours_p0   <= '0;
            minutes_p0 <= '0;
            seconds_p0 <= '0;
            tick_p0    <= 1'b0;
            wrap_p0    <= 1'b0;
            err_p0     <= 1'b0;
        end else begin
            tick_p0 <= tick && !load;
            wrap_p0 <= tick && !load && sec_last && min_last && hour_last;
            err_p0  <= set_en && !set_legal;
            if (load) begin
                presc_p0   <= '0;
                hours_p0   <= set_hours;
                minutes_p0 <= set_minutes;
                seconds_p0 <= set_seconds;
            end else begin
                if (run)
                    presc_p0 <= (presc_p0 == PRESC_LAST) ? '0 : presc_p0 + PRESC_W'(1);
                if (tick) begin
                    if (sec_last) begin
                        seconds_p0 <= '0;
                        if (min_last) begin
                            minutes_p0 <= '0;
                            hours_p0   <= hour_last ? 6'd0 : hours_p0 + 6'd1;
                        end else begin
                            minutes_p0 <= minutes_p0 + 6'd1;
                        end
                    end else begin
                        seconds_p0 <= seconds_p0 + 6'd1;
                    end
                end
            end
        end
    end

    // Stage p1: registered display digits and pulses, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_digit_1   <= 4'd0;
            h_digit_0   <= 4'd0;
            m_digit_1   <= 4'd0;
            m_digit_0   <= 4'd0;
            s_digit_1   <= 4'd0;
            s_digit_0   <= 4'd0;
            am_pm_form  <= 1'b0;
            second_tick <= 1'b0;
            day_wrap    <= 1'b0;
            set_err     <= 1'b0;
        end else begin
            {h_digit_1, h_digit_0} <= to_bcd(disp_hour(hours_p0, hour_format));
            {m_digit_1, m_digit_0} <= to_bcd(minutes_p0);
            {s_digit_1, s_digit_0} <= to_bcd(seconds_p0);
            am_pm_form  <= hour_format && (hours_p0 >= 6'd12);
            second_tick <= tick_p0;
            day_wrap    <= wrap_p0;
            set_err     <= err_p0;
        end
    end

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Bench for rtc_time_keeper: seconds-of-day reference model checked every cycle,
// plus directed scenarios with hand-computed digit expectations.
module tb_rtc_time_keeper;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       hour_format;
    logic       set_en;
    logic [5:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic [3:0] h_digit_1, h_digit_0, m_digit_1, m_digit_0, s_digit_1, s_digit_0;
    logic       am_pm_form, second_tick, day_wrap, set_err;

    int errors = 0;
    int checks = 0;

    rtc_time_keeper #(.TICK_DIV(TD), .PRESC_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .hour_format(hour_format),
        .set_en(set_en), .set_hours(set_hours), .set_minutes(set_minutes),
        .set_seconds(set_seconds),
        .h_digit_1(h_digit_1), .h_digit_0(h_digit_0),
        .m_digit_1(m_digit_1), .m_digit_0(m_digit_0),
        .s_digit_1(s_digit_1), .s_digit_0(s_digit_0),
        .am_pm_form(am_pm_form), .second_tick(second_tick),
        .day_wrap(day_wrap), .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time of day as a count of seconds, prescaler as an integer.
    function automatic logic [23:0] exp_digits(input int t, input logic fmt12);
        int h, m, s, d;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        d = h;
        if (fmt12) d = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    int          m_time, m_presc;
    logic        m_tick, m_wrap, m_err, started = 1'b0;
    logic [23:0] e_digits;
    logic        e_pm, e_tick, e_wrap, e_err;
    logic        m_legal, m_tickc;

    assign m_legal = (set_hours <= 6'd23) && (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
    assign m_tickc = run && (m_presc == TD - 1);

    always @(posedge clk) begin
        if (rst) begin
            m_time   <= 0;
            m_presc  <= 0;
            m_tick   <= 1'b0;
            m_wrap   <= 1'b0;
            m_err    <= 1'b0;
            e_digits <= '0;
            e_pm     <= 1'b0;
            e_tick   <= 1'b0;
            e_wrap   <= 1'b0;
            e_err    <= 1'b0;
            started  <= 1'b1;
        end else begin
            e_digits <= exp_digits(m_time, hour_format);
            e_pm     <= hour_format && (m_time >= 12 * 3600);
            e_tick   <= m_tick;
            e_wrap   <= m_wrap;
            e_err    <= m_err;
            m_err    <= set_en && !m_legal;
            if (set_en && m_legal) begin
                m_time  <= int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
                m_presc <= 0;
                m_tick  <= 1'b0;
                m_wrap  <= 1'b0;
            end else begin
                if (run) m_presc <= (m_presc == TD - 1) ? 0 : m_presc + 1;
                m_tick <= m_tickc;
                m_wrap <= m_tickc && (m_time == 86399);
                if (m_tickc) m_time <= (m_time + 1) % 86400;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_digits", {8'h0, h_digit_1, h_digit_0, m_digit_1, m_digit_0, s_digit_1, s_digit_0},
                {8'h0, e_digits});
            chk("model_am_pm", {31'h0, am_pm_form}, {31'h0, e_pm});
            chk("model_second_tick", {31'h0, second_tick}, {31'h0, e_tick});
            chk("model_day_wrap", {31'h0, day_wrap}, {31'h0, e_wrap});
            chk("model_set_err", {31'h0, set_err}, {31'h0, e_err});
        end
    end

    function automatic logic [31:0] all_digits();
        return {8'h0, h_digit_1, h_digit_0, m_digit_1, m_digit_0, s_digit_1, s_digit_0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        set_hours   = h;
        set_minutes = m;
        set_seconds = s;
        set_en      = 1'b1;
        @(negedge clk);
        set_en      = 1'b0;
    endtask

    initial begin
        int cnt;
        int first;
        rst = 1'b1; run = 1'b0; hour_format = 1'b0; set_en = 1'b0;
        set_hours = '0; set_minutes = '0; set_seconds = '0;
        step(2);
        chk("reset_digits", all_digits(), 32'h0);
        chk("reset_pulses", {28'h0, am_pm_form, second_tick, day_wrap, set_err}, 32'h0);
        rst = 1'b0;

        // Free run from zero: a tick every 4 cycles
        run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 13; i++) begin
            step(1);
            if (second_tick === 1'b1) cnt++;
        end
        chk("run_tick_count", cnt, 3);
        chk("run_digits", all_digits(), 32'h000003);

        // Day wrap
        load(6'd23, 6'd59, 6'd58);
        step(1);
        chk("wrap_loaded", all_digits(), 32'h235958);
        step(4);
        chk("wrap_59", all_digits(), 32'h235959);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (day_wrap === 1'b1) begin
                cnt++;
                chk("wrap_with_tick", {31'h0, second_tick}, 32'h1);
            end
        end
        chk("wrap_count", cnt, 1);
        chk("wrap_zero", all_digits(), 32'h000000);

        // 12-hour display
        hour_format = 1'b1;
        load(6'd0, 6'd30, 6'd0);
        step(1);
        chk("h12_midnight", all_digits(), 32'h123000);
        chk("h12_midnight_pm", {31'h0, am_pm_form}, 32'h0);
        load(6'd12, 6'd0, 6'd0);
        step(1);
        chk("h12_noon", all_digits(), 32'h120000);
        chk("h12_noon_pm", {31'h0, am_pm_form}, 32'h1);
        load(6'd13, 6'd5, 6'd9);
        step(1);
        chk("h12_13h", all_digits(), 32'h010509);
        chk("h12_13h_pm", {31'h0, am_pm_form}, 32'h1);
        hour_format = 1'b0;
        step(1);
        chk("h24_13h", all_digits(), 32'h130509);
        chk("h24_13h_pm", {31'h0, am_pm_form}, 32'h0);

        // Illegal loads while running
        load(6'd24, 6'd0, 6'd0);
        step(1);
        chk("bad_hour_err", {31'h0, set_err}, 32'h1);
        chk("bad_hour_keep", all_digits(), 32'h130509);
        step(1);
        chk("bad_hour_err_clear", {31'h0, set_err}, 32'h0);
        load(6'd10, 6'd60, 6'd0);
        step(1);
        chk("bad_min_err", {31'h0, set_err}, 32'h1);
        chk("bad_min_hour", {24'h0, h_digit_1, h_digit_0}, 32'h13);

        // Load coincident with the tick cycle
        load(6'd5, 6'd10, 6'd20);
        step(3);
        load(6'd7, 6'd8, 6'd9);
        step(1);
        chk("coinc_loaded", all_digits(), 32'h070809);
        chk("coinc_no_tick", {31'h0, second_tick}, 32'h0);
        first = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            if (second_tick === 1'b1 && first == 0) first = i;
        end
        chk("coinc_next_tick", first, 4);
        chk("coinc_after", all_digits(), 32'h070810);

        // Hold, then reset with a pending load and tick
        run = 1'b0;
        step(10);
        chk("hold_frozen", all_digits(), 32'h070810);
        run = 1'b1;
        step(2);
        rst = 1'b1;
        load(6'd11, 6'd11, 6'd11);
        chk("rst_digits", all_digits(), 32'h0);
        chk("rst_pulses", {28'h0, am_pm_form, second_tick, day_wrap, set_err}, 32'h0);
        rst = 1'b0;
        step(1);
        chk("rst_load_ignored", all_digits(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
